// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and the
// queued command entry layout.
package alu_pkg;

    localparam logic [3:0] ADD       = 4'h0;
    localparam logic [3:0] SUB       = 4'h1;
    localparam logic [3:0] SHL       = 4'h2;
    localparam logic [3:0] SHR       = 4'h3;
    localparam logic [3:0] AND       = 4'h4;
    localparam logic [3:0] OR        = 4'h5;
    localparam logic [3:0] XOR       = 4'h6;
    localparam logic [3:0] NOT       = 4'h7;
    localparam logic [3:0] DEC       = 4'h8;
    localparam logic [3:0] INC       = 4'h9;
    localparam logic [3:0] MODE_LAST = 4'h9;

    localparam int CMD_W = 37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        use_acc;
        logic [3:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_entry_t;

    function automatic logic mode_is_legal(input logic [3:0] mode);
        return (mode <= MODE_LAST);
    endfunction

    // Only add/subtract produce a meaningful carry/borrow in bit 16.
    function automatic logic mode_has_carry(input logic [3:0] mode);
        return (mode == ADD) || (mode == SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Bundle of command, ALU-operand and result channels of the sequencer.
// slave is the sequencer side, master is the producer/ALU/consumer side.
interface alu_cmd_seq_if #(parameter int W = 16);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_mode;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_use_acc;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_mode;
    logic [W:0]   alu_out;

    logic         res_valid;
    logic         res_ready;
    logic [W:0]   res_data;
    logic         res_zero;
    logic         res_carry;
    logic         res_illegal;

    modport master (
        output cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_use_acc, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_data,
               res_zero, res_carry, res_illegal
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_use_acc, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_data,
               res_zero, res_carry, res_illegal
    );

endinterface

// File: rtl/alu_cmd_seq_cmd_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count; head entry is
// presented combinationally on dout.
module cmd_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign wr_en_s = push && (count_r != FULL_CNT);
    assign rd_en_s = pop  && (count_r != (AW+1)'(0));

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == (AW+1)'(0));
    assign count = count_r;

endmodule

// File: rtl/alu_cmd_seq.sv
// Sequencer in front of the 16-bit combinational ALU: queues commands, issues
// them one at a time, captures result plus flags, optionally chains the result.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input logic         clk,
    input logic         rst_n,
    alu_cmd_seq_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cmd_entry_t    push_entry_s;
    cmd_entry_t    head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [AW:0]   fifo_count_s;
    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic          capture_s;
    logic          release_s;

    state_t        state_r;
    state_t        state_next_s;

    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic [3:0]    alu_mode_r;
    logic [W-1:0]  acc_r;
    logic          res_valid_r;
    logic [W:0]    res_data_r;
    logic          res_zero_r;
    logic          res_carry_r;
    logic          res_illegal_r;

    assign push_entry_s = '{use_acc: bus.cmd_use_acc, mode: bus.cmd_mode,
                            a: bus.cmd_a, b: bus.cmd_b};
    assign push_s       = bus.cmd_valid && !fifo_full_s;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control strobes; DONE may release and reload in one cycle
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    load_s       = 1'b1;
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                capture_s    = 1'b1;
                state_next_s = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    release_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        load_s       = 1'b1;
                        state_next_s = DRIVE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand/opcode registers driving the ALU; acc is already current at load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r    <= {W{1'b0}};
            alu_b_r    <= {W{1'b0}};
            alu_mode_r <= 4'h0;
        end else if (load_s) begin
            alu_a_r    <= head_s.use_acc ? acc_r : head_s.a;
            alu_b_r    <= head_s.b;
            alu_mode_r <= head_s.mode;
        end
    end

    // Result capture, status flags and accumulator update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r   <= 1'b0;
            res_data_r    <= {(W+1){1'b0}};
            res_zero_r    <= 1'b0;
            res_carry_r   <= 1'b0;
            res_illegal_r <= 1'b0;
            acc_r         <= {W{1'b0}};
        end else if (capture_s) begin
            res_valid_r <= 1'b1;
            if (mode_is_legal(alu_mode_r)) begin
                res_data_r    <= bus.alu_out;
                res_zero_r    <= (bus.alu_out[W-1:0] == {W{1'b0}});
                res_carry_r   <= mode_has_carry(alu_mode_r) & bus.alu_out[W];
                res_illegal_r <= 1'b0;
                acc_r         <= bus.alu_out[W-1:0];
            end else begin
                res_data_r    <= {(W+1){1'b0}};
                res_zero_r    <= 1'b1;
                res_carry_r   <= 1'b0;
                res_illegal_r <= 1'b1;
            end
        end else if (release_s) begin
            res_valid_r <= 1'b0;
        end
    end

    assign bus.cmd_ready   = (fifo_count_s != FULL_CNT);
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_mode    = alu_mode_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_data    = res_data_r;
    assign bus.res_zero    = res_zero_r;
    assign bus.res_carry   = res_carry_r;
    assign bus.res_illegal = res_illegal_r;

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer directly upstream of the 16-bit combinational ALU. Buffers {mode, A, B} commands from a valid/ready producer and drives them one at a time onto the ALU operand/mode lines. Captures the 17-bit ALU result with status flags and returns it on a valid/ready result channel. Optionally chains the previous result into operand A for accumulator-style sequences.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- W, 16: operand width; fixed at 16 to match the ALU.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  = FIFO not full.
- cmd_mode  in  4  ALU opcode.
- cmd_a, cmd_b  in  16 each  operands.
- cmd_use_acc  in  1  replace A with accumulator at issue.
- alu_a, alu_b  out  16 each  registered operands to ALU.
- alu_mode  out  4  registered opcode to ALU.
- alu_out  in  17  combinational ALU result.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_data  out  17  captured result.
- res_zero, res_carry, res_illegal  out  1 each  status flags.

## Operation
- Push on cmd_valid && cmd_ready. FIFO entry is 37 bits {use_acc, mode, a, b}. No push when full, even if a pop occurs in the same cycle.
- FSM states IDLE, DRIVE, DONE:
  - IDLE: if FIFO non-empty, pop head, load alu_* registers, go to DRIVE.
  - DRIVE: capture alu_out into res_data, compute flags, set res_valid=1, update acc, go to DONE.
  - DONE: on res_ready, clear res_valid. In the same cycle, if FIFO is non-empty, pop and load the next command and go to DRIVE; otherwise go to IDLE. Without res_ready, hold all outputs.
- Operand A at load is acc when use_acc=1, else the entry's a. acc = res_data[15:0] of the last captured result; acc resets to 0.
  - Because each load follows the previous capture, chaining is hazard-free.
- Illegal opcode (mode > 4'h9):
  - res_data=0 and res_illegal=1.
  - acc is left unchanged.
  - alu_out is ignored for that command.
- Flags:
  - res_zero = (res_data[15:0]==0).
  - res_carry = res_data[16] for modes 0x0/0x1 only, else 0.
  - res_illegal=0 for legal modes.
- Capacity is DEPTH queued plus 1 in flight. Results return in command order.

## Timing
- Reset values:
  - cmd_ready=1 (count=0).
  - alu_a, alu_b, alu_mode = 0.
  - res_valid=0, res_data=0, all flags 0, acc=0, FSM=IDLE.
- Reset mid-operation discards the queued command, the in-flight command and any unread result. No result is emitted after release.
- Latency: command accepted at edge T into an idle, empty block → alu_* valid after T+1 → res_valid high after T+2.
- Peak throughput is one result per 2 cycles with res_ready held high.
- The ALU path is combinational within the DRIVE cycle: alu_* to alu_out must meet one clock period.
- res_data and flags are stable while res_valid=1 && res_ready=0.
- cmd_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after a pop from full.

## Structure
- Shared package alu_pkg holds:
  - opcode constants ADD=0x0, SUB=0x1, SHL=0x2, SHR=0x3, AND=0x4, OR=0x5, XOR=0x6, NOT=0x7, DEC=0x8, INC=0x9;
  - MODE_LAST=0x9;
  - the FSM state enum;
  - the 37-bit command entry type.
- One sub-module, cmd_fifo: synchronous FIFO parameterized by width and depth, with full/empty flags and a count of clog2(DEPTH)+1 bits. FSM, acc and flag logic stay in alu_cmd_seq.

## Test plan
- Add with carry: ADD a=0x0001 b=0xFFFF, res_ready=1 → 2 cycles after accept, res_data=0x10000, res_zero=1, res_carry=1.
- Chain: ADD 5+3, then XOR use_acc=1 b=0x000F → alu_a=0x0008 on the second issue; results 0x00008 then 0x00007.
- Backpressure: res_ready=0, offer 6 back-to-back commands → 5 accepted and cmd_ready=0. Then res_ready=1 → 5 results in order with no loss or duplication.
- Illegal: mode 0xC a=0x1234 → res_data=0, res_illegal=1, acc unchanged. A following INC use_acc=1 uses the pre-illegal acc.
- Non-add carry: SHL a=0x8000 with alu_out[16]=1 → res_carry=0, res_zero=1.
- Reset: drop rst_n low while in DRIVE with 3 commands queued → after release res_valid=0, cmd_ready=1, alu_*=0, and no result appears within 10 cycles.
